// File: rtl/act_vec_loader.sv
// Byte-stream to parallel-vector loader for one fully-connected neuron node; holds the vector for LAT edges, then streams out the node result.
// Optional s_last framing, short/long frame handling and m_err: define ACT_VEC_LOADER_LAST_FRAMING_EN.
module act_vec_loader #(
  parameter int unsigned N_IN = 30,
  parameter int unsigned DW   = 8,
  parameter int unsigned LAT  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DW-1:0]      s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [N_IN*DW-1:0] vec_out,
  input  logic [DW-1:0]      node_in,
  output logic [DW-1:0]      m_data,
  output logic               m_valid,
  output logic               m_err,
  input  logic               m_ready,
  output logic               busy
);

  localparam int unsigned IDX_W = $clog2(N_IN + 1);
  localparam int unsigned CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(N_IN);
  localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(LAT);
`ifndef ACT_VEC_LOADER_LAST_FRAMING_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
`endif

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N_IN-1:0][DW-1:0] vec_q, vec_d;
  logic [DW-1:0]           m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    frame_done;
`ifdef ACT_VEC_LOADER_LAST_FRAMING_EN
  logic                    err_q, err_d;
  logic                    m_err_q, m_err_d;
`else
  logic                    unused_s_last;
  assign unused_s_last = s_last;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    frame_done = 1'b0;
`ifdef ACT_VEC_LOADER_LAST_FRAMING_EN
    err_d      = err_q;
    m_err_d    = m_err_q;
`endif
    unique case (state_q)
      FILL: begin
        if (s_valid) begin
          // Index saturates at N_IN so surplus bytes of a long frame are dropped.
          if (idx_q < FULL_IDX) begin
            vec_d[idx_q] = s_data;
            idx_d        = idx_q + 1'b1;
          end
`ifdef ACT_VEC_LOADER_LAST_FRAMING_EN
          if (idx_q >= FULL_IDX) err_d = 1'b1;
          frame_done = s_last;
`else
          frame_done = (idx_q == LAST_IDX);
`endif
          if (frame_done) begin
`ifdef ACT_VEC_LOADER_LAST_FRAMING_EN
            for (int unsigned k = 0; k < N_IN; k++) begin
              if (IDX_W'(k) > idx_q) vec_d[k] = '0;
            end
`endif
            cnt_d   = LAT_CNT;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          m_data_d  = node_in;
          m_valid_d = 1'b1;
`ifdef ACT_VEC_LOADER_LAST_FRAMING_EN
          m_err_d   = err_q;
`endif
          state_d   = OUT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          idx_d     = '0;
`ifdef ACT_VEC_LOADER_LAST_FRAMING_EN
          err_d     = 1'b0;
`endif
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FILL;
      idx_q     <= '0;
      cnt_q     <= '0;
      vec_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
`ifdef ACT_VEC_LOADER_LAST_FRAMING_EN
      err_q     <= 1'b0;
      m_err_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      vec_q     <= vec_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
`ifdef ACT_VEC_LOADER_LAST_FRAMING_EN
      err_q     <= err_d;
      m_err_q   <= m_err_d;
`endif
    end
  end

  assign s_ready = (state_q == FILL);
  assign busy    = (state_q != FILL);
  assign vec_out = vec_q;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
`ifdef ACT_VEC_LOADER_LAST_FRAMING_EN
  assign m_err   = m_err_q;
`else
  assign m_err   = 1'b0;
`endif

endmodule

// File: tb/tb_act_vec_loader.sv
// Bench for act_vec_loader: frame-level reference model checked every cycle, plus directed literal checks.
module tb_act_vec_loader;
  localparam int N_IN = 30;
  localparam int DW   = 8;
  localparam int LAT  = 3;
`ifdef ACT_VEC_LOADER_LAST_FRAMING_EN
  localparam bit FRAMING = 1'b1;
`else
  localparam bit FRAMING = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [DW-1:0]      s_data = '0;
  logic               s_valid = 1'b0;
  logic               s_last = 1'b0;
  logic               s_ready;
  logic [N_IN*DW-1:0] vec_out;
  logic [DW-1:0]      node_in = '0;
  logic [DW-1:0]      m_data;
  logic               m_valid;
  logic               m_err;
  logic               m_ready = 1'b0;
  logic               busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] frame_q[$];

  act_vec_loader #(.N_IN(N_IN), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .reset(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .vec_out(vec_out), .node_in(node_in),
    .m_data(m_data), .m_valid(m_valid), .m_err(m_err), .m_ready(m_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N_IN*DW-1:0] act, input logic [N_IN*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: a frame is the list of accepted bytes; the result
  // appears LAT+1 edges after the completing accept and waits for m_ready.
  bit         md_fill = 1'b1;
  int         md_n = 0;
  int         md_wait = 0;
  bit         md_valid = 1'b0;
  logic [7:0] md_data = '0;
  bit         md_err = 1'b0;
  logic [7:0] ml[N_IN];

  task automatic model_step();
    if (!rst_n) begin
      md_fill = 1'b1; md_n = 0; md_wait = 0; md_valid = 1'b0; md_data = '0; md_err = 1'b0;
      for (int k = 0; k < N_IN; k++) ml[k] = '0;
    end else if (md_fill) begin
      if (s_valid) begin
        if (md_n < N_IN) ml[md_n] = s_data;
        md_n++;
        if (FRAMING ? s_last : (md_n == N_IN)) begin
          for (int k = md_n; k < N_IN; k++) ml[k] = '0;
          md_err  = FRAMING && (md_n > N_IN);
          md_fill = 1'b0;
          md_wait = LAT + 1;
        end
      end
    end else if (!md_valid) begin
      md_wait--;
      if (md_wait == 0) begin
        md_valid = 1'b1;
        md_data  = node_in;
      end
    end else if (m_ready) begin
      md_valid = 1'b0;
      md_fill  = 1'b1;
      md_n     = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  task automatic compare();
    logic [N_IN*DW-1:0] ev;
    for (int k = 0; k < N_IN; k++) ev[k*DW +: DW] = ml[k];
    chk("cyc_s_ready", s_ready, md_fill);
    chk("cyc_busy", busy, !md_fill);
    chk("cyc_m_valid", m_valid, md_valid);
    chk("cyc_vec_out", vec_out, ev);
    if (md_valid) begin
      chk("cyc_m_data", m_data, md_data);
      chk("cyc_m_err", m_err, md_err);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) compare();
  end

  task automatic put_byte(input logic [7:0] d, input logic last);
    int n = 0;
    s_data = d; s_valid = 1'b1; s_last = last;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL put_byte: s_ready stuck low got 0 expected 1");
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int last_at);
    foreach (frame_q[i]) put_byte(frame_q[i], i == last_at);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!m_valid) begin
      checks++; errors++;
      $display("FAIL wait_valid: m_valid got 0 expected 1 within 100 cycles");
    end
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_err"}, m_err, 0);
    chk({tag, "_vec_out"}, vec_out, 0);
  endtask

  initial begin
    int n;
    #2 rst_n = 1'b0;
    #1 chk_reset("por");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Full frame 0x01..0x1E, result 0x2A after LAT+1 edges.
    @(negedge clk);
    node_in = 8'h2A;
    frame_q.delete();
    for (int k = 0; k < N_IN; k++) frame_q.push_back(8'(k + 1));
    send_frame(N_IN - 1);
    chk("t1_s_ready_low", s_ready, 0);
    chk("t1_busy", busy, 1);
    wait_valid(n);
    chk("t1_latency", n, LAT + 1);
    chk("t1_m_data", m_data, 8'h2A);
    chk("t1_m_err", m_err, 0);
    for (int k = 0; k < N_IN; k++) chk($sformatf("t1_lane%0d", k), vec_out[k*DW +: DW], 8'(k + 1));
    handshake();

    // Back-pressure: result must stay put while node_in toggles.
    node_in = 8'h55;
    frame_q.delete();
    for (int k = 0; k < N_IN; k++) frame_q.push_back(8'hC0 ^ 8'(k));
    send_frame(N_IN - 1);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      node_in = ~node_in;
      chk("t2_m_data_hold", m_data, 8'h55);
      chk("t2_m_valid_hold", m_valid, 1);
      chk("t2_s_ready", s_ready, 0);
      chk("t2_busy", busy, 1);
    end
    handshake();
    chk("t2_m_valid_drop", m_valid, 0);
    chk("t2_s_ready_back", s_ready, 1);

    // Reset pulse during the second HOLD cycle aborts the frame.
    node_in = 8'h33;
    frame_q.delete();
    for (int k = 0; k < N_IN; k++) frame_q.push_back(8'h10 + 8'(k));
    send_frame(N_IN - 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("t3_rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t3_no_valid", m_valid, 0);
    end
    node_in = 8'h66;
    frame_q.delete();
    for (int k = 0; k < N_IN; k++) frame_q.push_back(8'(N_IN - k));
    send_frame(N_IN - 1);
    wait_valid(n);
    chk("t3_latency", n, LAT + 1);
    chk("t3_m_data", m_data, 8'h66);
    for (int k = 0; k < N_IN; k++) chk($sformatf("t3_lane%0d", k), vec_out[k*DW +: DW], 8'(N_IN - k));
    handshake();

`ifdef ACT_VEC_LOADER_LAST_FRAMING_EN
    node_in = 8'h01;
    frame_q.delete();
    for (int k = 0; k < N_IN; k++) frame_q.push_back(8'hFF);
    send_frame(N_IN - 1);
    wait_valid(n);
    handshake();

    // Short frame after all-0xFF frame: tail lanes zero-filled.
    node_in = 8'h02;
    frame_q.delete();
    for (int k = 0; k < 5; k++) frame_q.push_back(8'h7F);
    send_frame(4);
    wait_valid(n);
    chk("t4_m_err", m_err, 0);
    for (int k = 0; k < N_IN; k++) chk($sformatf("t4_lane%0d", k), vec_out[k*DW +: DW], (k < 5) ? 8'h7F : 8'h00);
    handshake();

    // Long frame: first N_IN bytes kept, error flagged.
    node_in = 8'h03;
    frame_q.delete();
    for (int k = 0; k < 32; k++) frame_q.push_back(8'(k));
    send_frame(31);
    wait_valid(n);
    chk("t5_m_err", m_err, 1);
    for (int k = 0; k < N_IN; k++) chk($sformatf("t5_lane%0d", k), vec_out[k*DW +: DW], 8'(k));
    handshake();

    node_in = 8'h04;
    frame_q.delete();
    for (int k = 0; k < N_IN; k++) frame_q.push_back(8'h80 + 8'(k));
    send_frame(N_IN - 1);
    wait_valid(n);
    chk("t5_clean_m_err", m_err, 0);
    handshake();

    // Single-byte frame.
    node_in = 8'h05;
    frame_q.delete();
    frame_q.push_back(8'h99);
    send_frame(0);
    wait_valid(n);
    chk("t6_latency", n, LAT + 1);
    for (int k = 0; k < N_IN; k++) chk($sformatf("t6_lane%0d", k), vec_out[k*DW +: DW], (k == 0) ? 8'h99 : 8'h00);
    handshake();
`else
    // s_last has no effect: frame runs to byte N_IN-1.
    node_in = 8'h77;
    for (int k = 0; k < N_IN; k++) begin
      put_byte(8'h40 + 8'(k), k == 3);
      if (k == 3) begin
        chk("t7_s_ready_after_last", s_ready, 1);
        chk("t7_busy_after_last", busy, 0);
      end
    end
    chk("t7_s_ready_end", s_ready, 0);
    wait_valid(n);
    chk("t7_latency", n, LAT + 1);
    chk("t7_m_err", m_err, 0);
    chk("t7_m_data", m_data, 8'h77);
    for (int k = 0; k < N_IN; k++) chk($sformatf("t7_lane%0d", k), vec_out[k*DW +: DW], 8'h40 + 8'(k));
    handshake();
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation end got not-reached expected reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/act_vec_loader.md
# act_vec_loader

Streaming front end for one fully-connected neuron node. It accepts activations one byte per cycle over a valid/ready stream and packs them into the node's parallel input vector. It holds that vector stable for the node's fixed pipeline latency, then captures the node's 8-bit result. The result goes out on a second valid/ready stream. This is the producer side of the node's A0x..A(N-1)x input bus and the consumer side of its Nx output, so a layer can be driven from a byte stream instead of wide parallel buses.

## Interface
- N_IN, 30, activation lanes per vector (node fan-in)
- DW, 8, bits per activation/result
- LAT, 3, node latency in clock edges from a stable input vector to a valid Nx output
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- s_data  in  DW  activation byte; lane index is its position in the frame
- s_valid  in  1  s_data valid
- s_last  in  1  final byte of frame (qualified by s_valid)
- s_ready  out  1  loader accepts a byte this cycle
- vec_out  out  N_IN*DW  lane k at bits [k*DW+DW-1 : k*DW]; drives node A{k}x
- node_in  in  DW  node result Nx
- m_data  out  DW  captured result
- m_valid  out  1  result valid
- m_err  out  1  framing error for this result, qualified by m_valid
- m_ready  in  1  downstream accepts result
- busy  out  1  high in HOLD or OUT

## Operation
- Reset (reset=0, asynchronous): state=FILL, lane index=0, vec_out=0, m_data=0, m_valid=0, m_err=0, hold count=0, s_ready=1, busy=0.
- States: FILL, HOLD, OUT.
- FILL:
  - s_ready=1. A byte is accepted on an edge with s_valid&&s_ready.
  - Accepted byte k (k<N_IN) is written to lane k, and the index increments.
  - The frame completes on the accept of s_last, which moves the state to HOLD.
- Short frame (s_last at index j<N_IN): lanes j+1..N_IN-1 are forced to 0 on the completing edge. The error flag is not set.
- Long frame (more than N_IN bytes before s_last):
  - Bytes with index ≥N_IN are accepted and discarded; lanes keep the first N_IN bytes.
  - The error flag is set and the frame still ends on s_last. The index saturates at N_IN; it never wraps.
- On the completing edge, the hold count is loaded with LAT and the error flag is latched for this frame.
- HOLD:
  - s_ready=0 and vec_out is frozen.
  - The count decrements every edge. On the edge where count==0: m_data<=node_in, m_err<=error flag, m_valid<=1, state=OUT.
- OUT:
  - s_ready=0. m_data and m_err are stable while m_valid && !m_ready.
  - On an edge with m_ready=1: m_valid<=0, index<=0, error flag<=0, state=FILL. Lanes are not cleared; the next frame overwrites them.
- s_ready is a combinational decode of the state only, with no path from s_valid or m_ready. m_valid is registered.
- vec_out is also updated during FILL. The node result is only sampled in HOLD, so partial vectors are harmless.

## Timing
- The last byte is accepted at edge E0. The node registers its inputs at E1, its sum at E2 and Nx at E3. Capture happens at E4 = E0+LAT+1, and m_valid is high from E4.
- Earliest next accept is the edge after the m_valid&&m_ready edge: one dead cycle. Minimum frame period is N_IN+LAT+2 cycles.
- A single-byte frame (s_last on byte 0) is legal: lane 0 is set and lanes 1..N_IN-1 are zeroed.
- Reset asserted mid-FILL, HOLD or OUT aborts immediately to reset values; no partial result is emitted.
- s_valid while s_ready=0 is ignored; the source must hold it until accepted.

## Configuration
- ACT_VEC_LOADER_LAST_FRAMING_EN defined: s_last framing, short/long frame handling and m_err behave as above.
- Not defined: s_last is ignored, m_err is tied 0, and a frame completes exactly on the accept of byte N_IN-1. No zero-fill is needed because every lane is written.

## Test plan
- 30 bytes 0x01..0x1E back-to-back, s_last on byte 29, node_in stub=0x2A:
  - lane k = k+1;
  - s_ready low from the edge after the byte-29 accept;
  - m_valid rises 4 edges after that accept, with m_data=0x2A, m_err=0.
- Short frame of 5 bytes 0x7F with s_last on byte 4, after a prior full frame of 0xFF:
  - lanes 0–4=0x7F, lanes 5–29=0x00, m_err=0.
- Long frame of 32 bytes 0x00..0x1F, s_last on byte 31:
  - lanes hold 0x00..0x1D, m_err=1 with m_valid;
  - the next clean frame returns m_err=0.
- m_ready held low for 10 cycles after m_valid, node_in toggling:
  - m_data and m_valid stable, s_ready=0, busy=1;
  - m_ready pulse gives m_valid=0 and s_ready=1 on the following cycle.
- reset pulsed low for 1 cycle on the second HOLD cycle:
  - all outputs at reset values asynchronously; no m_valid;
  - a fresh 30-byte frame then completes normally.
- Macro undefined, s_last asserted on byte 3:
  - frame does not end until byte 29; m_err stays 0.
